// File: rtl/inst_seq_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and the memories.
// The master side is the sequencer, the slave side is the memory system.
interface inst_seq_if #(
   parameter int PC_WIDTH = 64
);
   logic                imem_req;
   logic [PC_WIDTH-1:0] imem_addr;
   logic                imem_ready;
   logic [31:0]         imem_rdata;
   logic                dmem_req;
   logic                dmem_wen;
   logic                dmem_ready;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_wen,
      input  imem_ready, imem_rdata, dmem_ready
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_wen,
      output imem_ready, imem_rdata, dmem_ready
   );
endinterface

// File: rtl/inst_seq.sv
// Multi-cycle RV64 control sequencer: FETCH/DECODE/EXEC/[MEM]/WB with PC and instruction register.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module inst_seq #(
   parameter int                  PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic                clk,
   input  logic                rst,
   inst_seq_if.master          bus,
   output logic [31:0]         inst,
   input  logic [2:0]          inst_type,
   input  logic                br_taken,
   input  logic [PC_WIDTH-1:0] br_target,
   input  logic                halt,
   output logic                r_wen,
   output logic [PC_WIDTH-1:0] pc,
   output logic                retire,
   output logic                halted,
   output logic [63:0]         cycle_cnt,
   output logic [63:0]         instret_cnt
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [2:0] TYPE_S = 3'd2;
   localparam logic [2:0] TYPE_J = 3'd3;
   localparam logic [2:0] TYPE_B = 3'd5;

   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   logic [2:0]          state_reg, state_next;
   logic [PC_WIDTH-1:0] pc_reg, pc_next;
   logic [31:0]         inst_reg;
   logic                store_reg;
   logic                wen_reg;
   logic                jb_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH:  if (bus.imem_ready) state_next = S_DECODE;
         // Codes 6 and 7 are undefined decoder outputs and stop the core like ebreak
         S_DECODE: state_next = (halt || (inst_type[2] && inst_type[1])) ? S_HALT : S_EXEC;
         S_EXEC:   state_next = (inst_type == TYPE_S || inst_reg[6:0] == OPC_LOAD) ? S_MEM : S_WB;
         S_MEM:    if (bus.dmem_ready) state_next = S_WB;
         S_WB:     state_next = S_FETCH;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_FETCH;
      endcase
   end

   // Taken targets are forced to word alignment; everything else falls through
   always_comb begin
      if (jb_reg && br_taken)
         pc_next = br_target & ~PC_WIDTH'(3);
      else
         pc_next = pc_reg + PC_WIDTH'(4);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_FETCH;
         pc_reg    <= RESET_PC;
         inst_reg  <= 32'h0000_0013;
         store_reg <= 1'b0;
         wen_reg   <= 1'b0;
         jb_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_FETCH && bus.imem_ready)
            inst_reg <= bus.imem_rdata;
         // Latch per-instruction controls once so MEM/WB outputs stay pure state decodes
         if (state_reg == S_EXEC) begin
            store_reg <= (inst_type == TYPE_S);
            wen_reg   <= !(inst_type == TYPE_S || inst_type == TYPE_B);
            jb_reg    <= (inst_type == TYPE_J || inst_type == TYPE_B);
         end
         if (state_reg == S_WB)
            pc_reg <= pc_next;
      end
   end

   assign bus.imem_req  = (state_reg == S_FETCH);
   assign bus.imem_addr = pc_reg;
   assign bus.dmem_req  = (state_reg == S_MEM);
   assign bus.dmem_wen  = (state_reg == S_MEM) && store_reg;
   assign r_wen         = (state_reg == S_WB) && wen_reg;
   assign retire        = (state_reg == S_WB);
   assign halted        = (state_reg == S_HALT);
   assign inst          = inst_reg;
   assign pc            = pc_reg;

`ifdef PERF_CNT_EN
   logic [63:0] cycle_reg;
   logic [63:0] instret_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_reg   <= 64'd0;
         instret_reg <= 64'd0;
      end else begin
         cycle_reg <= cycle_reg + 64'd1;
         if (state_reg == S_WB)
            instret_reg <= instret_reg + 64'd1;
      end
   end

   assign cycle_cnt   = cycle_reg;
   assign instret_cnt = instret_reg;
`else
   assign cycle_cnt   = 64'd0;
   assign instret_cnt = 64'd0;
`endif
endmodule

// File: tb/tb_inst_seq.sv
// Table-driven bench for inst_seq: a memory responder, a retire-side scoreboard and
// hand-written sequences for halt, mid-MEM reset and PC wrap.
module tb_inst_seq;
   typedef struct {
      logic [2:0]  itype;
      logic [31:0] rdata;
      logic        bt;
      logic [63:0] tgt;
      int          iw;
      int          dw;
      int          lat;
      logic        rwen;
      int          dcyc;
      int          wcnt;
      logic [63:0] pc;
   } vec_t;

   logic        clk;
   logic        rst, rst_w;
   logic [2:0]  inst_type, inst_type_w;
   logic        br_taken, halt;
   logic [63:0] br_target;
   logic [31:0] inst, inst_w;
   logic        r_wen, retire, halted, r_wen_w, retire_w, halted_w;
   logic [63:0] pc, pc_w, cycle_cnt, instret_cnt, cycle_cnt_w, instret_cnt_w;

   inst_seq_if #(.PC_WIDTH(64)) bus ();
   inst_seq_if #(.PC_WIDTH(64)) bus_w ();

   inst_seq #(.PC_WIDTH(64), .RESET_PC(64'h8000_0000)) dut (
      .clk(clk), .rst(rst), .bus(bus), .inst(inst), .inst_type(inst_type),
      .br_taken(br_taken), .br_target(br_target), .halt(halt), .r_wen(r_wen),
      .pc(pc), .retire(retire), .halted(halted), .cycle_cnt(cycle_cnt),
      .instret_cnt(instret_cnt)
   );

   inst_seq #(.PC_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst_w), .bus(bus_w), .inst(inst_w), .inst_type(inst_type_w),
      .br_taken(1'b0), .br_target(64'd0), .halt(1'b0), .r_wen(r_wen_w),
      .pc(pc_w), .retire(retire_w), .halted(halted_w), .cycle_cnt(cycle_cnt_w),
      .instret_cnt(instret_cnt_w)
   );

   int checks = 0;
   int errors = 0;
   int retired_n = 0;
   int imem_wait = 0, dmem_wait = 0;
   logic [31:0] cur_rdata = 32'h0000_0013;
   vec_t sb[$];
   vec_t vecs[9];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      inst_type = v.itype;
      cur_rdata = v.rdata;
      br_taken  = v.bt;
      br_target = v.tgt;
      imem_wait = v.iw;
      dmem_wait = v.dw;
      sb.push_back(v);
   endtask

   // Memory responder: ready after the programmed wait; when idle, ready is high with junk data
   initial begin
      int iw_cnt = 0, dw_cnt = 0;
      bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; bus.dmem_ready = 1'b1;
      bus_w.imem_ready = 1'b1; bus_w.imem_rdata = 32'h0000_0013; bus_w.dmem_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst && bus.imem_req) begin
            bus.imem_ready = (iw_cnt >= imem_wait);
            bus.imem_rdata = bus.imem_ready ? cur_rdata : 32'hDEAD_BEEF;
            iw_cnt = bus.imem_ready ? 0 : iw_cnt + 1;
         end else begin
            bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; iw_cnt = 0;
         end
         if (rst && bus.dmem_req) begin
            bus.dmem_ready = (dw_cnt >= dmem_wait);
            dw_cnt = bus.dmem_ready ? 0 : dw_cnt + 1;
         end else begin
            bus.dmem_ready = 1'b1; dw_cnt = 0;
         end
      end
   end

   // Retire monitor: pops the scoreboard and checks latency, strobes, inst and next pc
   int lat = 0, dcyc = 0, wcnt = 0;
   logic pc_pend = 1'b0;
   logic [63:0] pc_exp = 64'd0;
   always @(negedge clk) begin
      vec_t e;
      if (!rst) begin
         lat = 0; dcyc = 0; wcnt = 0; pc_pend = 1'b0;
      end else begin
         if (pc_pend) begin
            chk("pc_after_wb", pc, pc_exp);
            pc_pend = 1'b0;
         end
         lat++;
         if (bus.dmem_req) dcyc++;
         if (bus.dmem_wen) wcnt++;
         if (retire) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_retire actual=1 required=0 pc=%0h", pc);
            end else begin
               e = sb.pop_front();
               chk("latency", 64'(lat), 64'(e.lat));
               chk("r_wen", {63'd0, r_wen}, {63'd0, e.rwen});
               chk("dmem_req_cycles", 64'(dcyc), 64'(e.dcyc));
               chk("dmem_wen_cycles", 64'(wcnt), 64'(e.wcnt));
               chk("inst_reg", {32'd0, inst}, {32'd0, e.rdata});
               $display("retire inst=%08h type=%0d lat=%0d r_wen=%0b dmem=%0d/%0d", inst,
                        e.itype, lat, r_wen, dcyc, wcnt);
               pc_exp = e.pc; pc_pend = 1'b1;
            end
            retired_n++;
            lat = 0; dcyc = 0; wcnt = 0;
         end
      end
   end

   initial begin
      int start;
      logic bad;
      vecs[0] = '{3'd0, 32'h0010_009B, 1'b0, 64'h0,           0, 0, 4, 1'b1, 0, 0, 64'h8000_0004};
      vecs[1] = '{3'd2, 32'h00A1_2023, 1'b0, 64'h0,           0, 3, 8, 1'b0, 4, 4, 64'h8000_0008};
      vecs[2] = '{3'd5, 32'h0000_0063, 1'b1, 64'h8000_0103,   0, 0, 4, 1'b0, 0, 0, 64'h8000_0100};
      vecs[3] = '{3'd5, 32'h0000_0063, 1'b0, 64'h9000_0000,   0, 0, 4, 1'b0, 0, 0, 64'h8000_0104};
      vecs[4] = '{3'd0, 32'h0001_2083, 1'b0, 64'h0,           2, 1, 8, 1'b1, 2, 0, 64'h8000_0108};
      vecs[5] = '{3'd1, 32'h0000_1037, 1'b1, 64'h0,           0, 0, 4, 1'b1, 0, 0, 64'h8000_010C};
      vecs[6] = '{3'd3, 32'h0000_006F, 1'b1, 64'h8000_0200,   0, 0, 4, 1'b1, 0, 0, 64'h8000_0200};
      vecs[7] = '{3'd4, 32'h0020_81B3, 1'b0, 64'h0,           1, 0, 5, 1'b1, 0, 0, 64'h8000_0204};
      vecs[8] = '{3'd3, 32'h0000_006F, 1'b0, 64'h8000_0400,   0, 0, 4, 1'b1, 0, 0, 64'h8000_0208};

      rst = 1'b0; rst_w = 1'b0; halt = 1'b0; inst_type = 3'd0; inst_type_w = 3'd0;
      br_taken = 1'b0; br_target = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pc", pc, 64'h8000_0000);
      chk("reset_inst", {32'd0, inst}, 64'h13);
      chk("reset_strobes", {59'd0, r_wen, retire, bus.dmem_req, bus.dmem_wen, halted}, 64'd0);
      chk("reset_cycle_cnt", cycle_cnt, 64'd0);
      chk("reset_instret_cnt", instret_cnt, 64'd0);
      chk("reset_imem_addr", bus.imem_addr, 64'h8000_0000);

      drive(vecs[0]);
      rst = 1'b1;
      for (int i = 0; i < 9; i++) begin
         start = retired_n;
         for (int c = 0; c < 60 && retired_n == start; c++) begin
            @(negedge clk); #1;
         end
         if (retired_n == start) begin
            checks++; errors++;
            $display("FAIL retire_timeout vec=%0d actual=none required=retire", i);
         end
         @(posedge clk); #1;
         if (i < 8) drive(vecs[i + 1]);
      end
`ifdef PERF_CNT_EN
      chk("instret_after_table", instret_cnt, 64'd9);
`else
      chk("cycle_cnt_disabled", cycle_cnt, 64'd0);
      chk("instret_cnt_disabled", instret_cnt, 64'd0);
`endif

      // Illegal type code in DECODE: halt and stay quiet
      inst_type = 3'd6; cur_rdata = 32'hFFFF_FFFF; imem_wait = 0;
      for (int c = 0; c < 20 && !halted; c++) begin
         @(negedge clk); #1;
      end
      chk("halted_illegal", {63'd0, halted}, 64'd1);
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.imem_req || bus.dmem_req || r_wen || retire || !halted) bad = 1'b1;
      end
      chk("halt_quiet_illegal", {63'd0, bad}, 64'd0);
      chk("halt_pc_frozen", pc, 64'h8000_0208);
      chk("halt_inst_frozen", {32'd0, inst}, 64'hFFFF_FFFF);
      $display("halt illegal pc=%0h halted=%0b", pc, halted);

      // ebreak flag in DECODE
      rst = 1'b0; #1;
      chk("reset_exits_halt", {63'd0, halted}, 64'd0);
      inst_type = 3'd0; halt = 1'b1; cur_rdata = 32'h0010_0073;
      @(posedge clk); #1 rst = 1'b1;
      for (int c = 0; c < 20 && !halted; c++) begin
         @(negedge clk); #1;
      end
      chk("halted_ebreak", {63'd0, halted}, 64'd1);
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.imem_req || bus.dmem_req || r_wen || retire || !halted) bad = 1'b1;
      end
      chk("halt_quiet_ebreak", {63'd0, bad}, 64'd0);
      chk("halt_pc_ebreak", pc, 64'h8000_0000);
      $display("halt ebreak pc=%0h halted=%0b", pc, halted);

      // Reset while a store waits in MEM
      rst = 1'b0; halt = 1'b0;
      inst_type = 3'd2; cur_rdata = 32'h00A1_2023; dmem_wait = 20;
      @(posedge clk); #1 rst = 1'b1;
      for (int c = 0; c < 20 && !bus.dmem_req; c++) begin
         @(negedge clk); #1;
      end
      chk("mem_entered", {63'd0, bus.dmem_req}, 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("abort_dmem_req", {62'd0, bus.dmem_req, bus.dmem_wen}, 64'd0);
      chk("abort_pc", pc, 64'h8000_0000);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("after_abort_fetch", {62'd0, bus.imem_req, bus.dmem_req}, 64'd2);
      chk("after_abort_pc", pc, 64'h8000_0000);
      $display("reset mid-MEM pc=%0h imem_req=%0b", pc, bus.imem_req);
      rst = 1'b0;

      // PC wrap on the second instance
      @(posedge clk); #1 rst_w = 1'b1;
      start = 0;
      for (int c = 0; c < 20 && !retire_w; c++) begin
         @(negedge clk); start++;
      end
      if (!retire_w) begin
         @(negedge clk); start++;
      end
      chk("wrap_latency", 64'(start), 64'd4);
      chk("wrap_r_wen", {63'd0, r_wen_w}, 64'd1);
      @(negedge clk);
      chk("wrap_pc", pc_w, 64'd0);
`ifdef PERF_CNT_EN
      chk("wrap_instret", instret_cnt_w, 64'd1);
      chk("wrap_cycle", cycle_cnt_w, 64'd4);
`else
      chk("wrap_counters_off", cycle_cnt_w | instret_cnt_w, 64'd0);
`endif
      $display("wrap pc=%0h", pc_w);
      rst_w = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/inst_seq.md
# inst_seq

Multi-cycle control sequencer for the RV64 core. It steps every instruction through FETCH, DECODE, EXEC, optional MEM, and WB, and owns the PC and instruction register. It handshakes with instruction and data memory and issues the one-cycle register-file write strobe. It consumes the 3-bit `inst_type` code from the decoder (TYPE_I=0, TYPE_U=1, TYPE_S=2, TYPE_J=3, TYPE_R=4, TYPE_B=5).

## Interface
Parameters:
- PC_WIDTH, 64, width of PC and addresses
- RESET_PC, 64'h8000_0000, PC loaded on reset

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_WIDTH  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- inst  out  32  instruction register, feeds decoder
- inst_type  in  3  decoder type code for `inst`
- br_taken  in  1  execute: branch/jump taken
- br_target  in  PC_WIDTH  execute: target address
- dmem_req  out  1  data access request
- dmem_wen  out  1  data access is a store
- dmem_ready  in  1  data access complete
- halt  in  1  decoder flags ebreak
- r_wen  out  1  register-file write strobe
- pc  out  PC_WIDTH  current PC
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  core stopped
- cycle_cnt  out  64  cycle counter (see Configuration)
- instret_cnt  out  64  retired-instruction counter

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1 and held until imem_ready.
  - On imem_ready: inst<=imem_rdata, go to DECODE.
  - imem_rdata is ignored without imem_ready.
- DECODE (1 cycle):
  - halt=1 -> HALT.
  - inst_type 6 or 7 (illegal) -> HALT.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - -> MEM if inst_type==TYPE_S or inst[6:0]==7'b0000011 (load).
  - Otherwise -> WB.
- MEM:
  - dmem_req=1; dmem_wen=1 for TYPE_S, else 0.
  - Held until dmem_ready, then -> WB.
- WB (1 cycle), then -> FETCH:
  - r_wen=1 for TYPE_I, TYPE_U, TYPE_J, TYPE_R and loads; r_wen=0 for TYPE_S and TYPE_B.
  - retire=1.
  - PC update: if br_taken and inst_type is TYPE_J or TYPE_B, pc<={br_target[PC_WIDTH-1:2],2'b00}; otherwise pc<=pc+4, wrapping modulo 2^PC_WIDTH.
- HALT:
  - Terminal; halted=1.
  - All requests and strobes are 0; pc and inst are frozen.
  - Only reset exits.
- imem_req, dmem_req, r_wen and retire are Moore outputs, decoded from the state register only.

## Timing
- Reset (rst=0, asynchronous):
  - state=FETCH, pc=RESET_PC, inst=32'h0000_0013 (nop).
  - r_wen=retire=dmem_req=dmem_wen=halted=0, both counters=0.
  - imem_req=1 from the first cycle after reset release.
- Reset asserted mid-operation aborts immediately. Outstanding imem/dmem requests are dropped without waiting for ready; memories must tolerate the abandoned request.
- Latency with zero-wait memories:
  - 4 cycles for non-memory instructions.
  - 5 cycles for loads and stores.
  - Each wait cycle adds 1.
- ready asserted in a cycle with no request is ignored.
- imem_ready and imem_rdata are sampled in the same cycle.
- br_taken and br_target are sampled only in WB and must be stable from EXEC through WB.
- pc is unchanged from FETCH through WB and updates on the WB->FETCH edge.

## Configuration
- PERF_CNT_EN defined:
  - cycle_cnt increments every cycle outside reset, including HALT.
  - instret_cnt increments on each retire.
  - Both are 64-bit and wrap at 2^64.
- PERF_CNT_EN undefined: both counters are removed and cycle_cnt and instret_cnt read constant 0.

## Test plan
- ALU instruction (TYPE_I): hold rst=0 then release, imem_ready=1 always, imem_rdata=32'h0010009B. Expect FETCH at pc=0x8000_0000, r_wen=1 and retire=1 in cycle 4, then pc=0x8000_0004.
- Store with wait state: TYPE_S with dmem_ready delayed 3 cycles. Expect dmem_req=1 and dmem_wen=1 for 4 cycles, r_wen=0, retire in cycle 8.
- Taken branch: TYPE_B with br_taken=1 and br_target=0x8000_0103. Expect pc=0x8000_0100 after WB and r_wen=0. A TYPE_B with br_taken=0 gives pc+4.
- Illegal and halt: inst_type=6 in DECODE -> halted=1 and imem_req=0 forever. Repeat with halt=1 and expect the same.
- Reset mid-MEM: assert rst=0 while dmem_req=1. Expect dmem_req=0 immediately, pc=RESET_PC and state FETCH after release.
- PC wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC with a non-branch instruction. Expect pc=0 after WB. With PERF_CNT_EN defined, instret_cnt=1 and cycle_cnt=4.
